seq_divider: RTL



---
 rtl/seq_divider.sv | 120 ++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider.
// Operands arrive over a valid/ready handshake, one quotient bit is resolved
// per clock, and the quotient/remainder pair leaves over a second valid/ready
// handshake. A zero divisor skips the iterations and returns a flagged result.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_dividend,
  input  logic [WIDTH-1:0] io_divisor,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_quotient,
  output logic [WIDTH-1:0] io_remainder,
  output logic             io_div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  // The partial remainder is always strictly below the divisor, so its
  // WIDTH+1-bit form has a zero top bit and only WIDTH bits are stored;
  // the extra bit appears only in the shifted value and the trial subtraction.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // State and datapath registers; reset returns to IDLE with cleared outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state logic: operand capture, one restoring step per BUSY cycle, result hand-off.
  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, div_q};

    unique case (state_q)
      IDLE: begin
        if (io_in_valid) begin
          div_d = io_divisor;
          cnt_d = CW'(WIDTH);
          if (io_divisor == '0) begin
            quo_d   = '1;
            rem_d   = io_dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            quo_d   = io_dividend;
            rem_d   = '0;
            dbz_d   = 1'b0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (io_out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign io_in_ready    = (state_q == IDLE) && !reset;
  assign io_out_valid   = (state_q == DONE);
  assign io_quotient    = quo_q;
  assign io_remainder   = rem_q;
  assign io_div_by_zero = dbz_q;

endmodule
